// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD timing engine:
// FSM states, default cycle counts, power-on init byte list, long-command test.
package lcd_pkg;

   typedef enum logic [2:0] {
      INIT_WAIT,
      INIT_ISSUE,
      IDLE,
      SETUP,
      PULSE,
      HOLD,
      WAIT
   } lcd_state_t;

   localparam int unsigned DEF_SETUP_CYC   = 2;
   localparam int unsigned DEF_PULSE_CYC   = 12;
   localparam int unsigned DEF_HOLD_CYC    = 2;
   localparam int unsigned DEF_EXEC_CYC    = 2000;
   localparam int unsigned DEF_LONG_CYC    = 82000;
   localparam int unsigned DEF_POWERUP_CYC = 750000;

   localparam int unsigned INIT_LEN = 6;
   // Entry 0 is issued first: 38 38 38 0C 01 06.
   localparam logic [INIT_LEN-1:0][7:0] INIT_BYTES =
      {8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38};

   // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return !rs && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_init_seq.sv
// Power-on init byte sequencer: 3-bit index into the package byte ROM.
// Used by lcd_driver only when LCD_INIT_SEQ_EN is defined.
module lcd_init_seq
   import lcd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       next,
   output logic [7:0] cmd_byte,
   output logic       done
);

   logic [2:0] idx;

   assign done = (idx >= 3'(INIT_LEN));

   always_ff @(posedge clk) begin
      if (rst)
         idx <= '0;
      else if (next && !done)
         idx <= idx + 3'd1;
   end

   always_comb begin
      cmd_byte = '0;
      if (!done)
         cmd_byte = INIT_BYTES[idx];
   end

endmodule

// File: rtl/lcd_driver.sv
// HD44780 character-LCD timing engine: one byte per valid/ready handshake, paced
// through SETUP/PULSE/HOLD/WAIT. Define LCD_INIT_SEQ_EN for the built-in power-on init.
module lcd_driver
   import lcd_pkg::*;
#(
   parameter int unsigned SETUP_CYC   = DEF_SETUP_CYC,
   parameter int unsigned PULSE_CYC   = DEF_PULSE_CYC,
   parameter int unsigned HOLD_CYC    = DEF_HOLD_CYC,
   parameter int unsigned EXEC_CYC    = DEF_EXEC_CYC,
   parameter int unsigned LONG_CYC    = DEF_LONG_CYC,
   parameter int unsigned POWERUP_CYC = DEF_POWERUP_CYC
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   input  logic       cmd_rs,
   input  logic [7:0] cmd_data,
   output logic       cmd_ready,
   output logic       lcd_on,
   output logic       lcd_en,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [7:0] lcd_data
);

   localparam int unsigned MAX_CYC = max_u(max_u(max_u(SETUP_CYC, PULSE_CYC), max_u(HOLD_CYC, EXEC_CYC)),
                                           max_u(max_u(LONG_CYC, POWERUP_CYC), 2));
   localparam int unsigned CW = $clog2(MAX_CYC);

   lcd_state_t    state;
   logic [CW-1:0] cnt;
   logic          long_q;

   assign lcd_rw = 1'b0;

`ifdef LCD_INIT_SEQ_EN
   logic       init_next;
   logic [7:0] init_byte;
   logic       init_done;

   assign init_next = (state == INIT_ISSUE);

   lcd_init_seq u_init_seq (
      .clk      (clk),
      .rst      (rst),
      .next     (init_next),
      .cmd_byte (init_byte),
      .done     (init_done)
   );
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= INIT_WAIT;
`ifdef LCD_INIT_SEQ_EN
         // Entering INIT_WAIT is a state entry, so the power-up count is preloaded here.
         cnt       <= CW'(POWERUP_CYC - 1);
`else
         cnt       <= '0;
`endif
         long_q    <= 1'b0;
         cmd_ready <= 1'b0;
         lcd_on    <= 1'b0;
         lcd_en    <= 1'b0;
         lcd_rs    <= 1'b0;
         lcd_data  <= '0;
      end else begin
         lcd_on <= 1'b1;
         if (cnt != '0)
            cnt <= cnt - CW'(1);
         case (state)
            INIT_WAIT: begin
`ifdef LCD_INIT_SEQ_EN
               if (cnt == '0)
                  state <= INIT_ISSUE;
`else
               state     <= IDLE;
               cmd_ready <= 1'b1;
`endif
            end
            INIT_ISSUE: begin
`ifdef LCD_INIT_SEQ_EN
               lcd_rs   <= 1'b0;
               lcd_data <= init_byte;
               long_q   <= is_long_cmd(1'b0, init_byte);
               cnt      <= CW'(SETUP_CYC - 1);
               state    <= SETUP;
`else
               state    <= IDLE;
`endif
            end
            IDLE: begin
               if (cmd_valid) begin
                  lcd_rs    <= cmd_rs;
                  lcd_data  <= cmd_data;
                  long_q    <= is_long_cmd(cmd_rs, cmd_data);
                  cmd_ready <= 1'b0;
                  cnt       <= CW'(SETUP_CYC - 1);
                  state     <= SETUP;
               end
            end
            SETUP: begin
               if (cnt == '0) begin
                  lcd_en <= 1'b1;
                  cnt    <= CW'(PULSE_CYC - 1);
                  state  <= PULSE;
               end
            end
            PULSE: begin
               if (cnt == '0) begin
                  lcd_en <= 1'b0;
                  cnt    <= CW'(HOLD_CYC - 1);
                  state  <= HOLD;
               end
            end
            HOLD: begin
               if (cnt == '0) begin
                  cnt   <= long_q ? CW'(LONG_CYC - 1) : CW'(EXEC_CYC - 1);
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
`ifdef LCD_INIT_SEQ_EN
                  if (!init_done) begin
                     state <= INIT_ISSUE;
                  end else begin
                     state     <= IDLE;
                     cmd_ready <= 1'b1;
                  end
`else
                  state     <= IDLE;
                  cmd_ready <= 1'b1;
`endif
               end
            end
            default: state <= INIT_WAIT;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_driver.sv
// Directed testbench for lcd_driver with shortened timing parameters.
// Covers LCD_INIT_SEQ_EN builds through test_init when the macro is defined.
module tb_lcd_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_rs = 1'b0;
   logic [7:0] cmd_data = '0;
   logic       cmd_ready;
   logic       lcd_on;
   logic       lcd_en;
   logic       lcd_rs;
   logic       lcd_rw;
   logic [7:0] lcd_data;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   lcd_driver #(
      .SETUP_CYC   (2),
      .PULSE_CYC   (3),
      .HOLD_CYC    (2),
      .EXEC_CYC    (5),
      .LONG_CYC    (20),
      .POWERUP_CYC (10)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_rs    (cmd_rs),
      .cmd_data  (cmd_data),
      .cmd_ready (cmd_ready),
      .lcd_on    (lcd_on),
      .lcd_en    (lcd_en),
      .lcd_rs    (lcd_rs),
      .lcd_rw    (lcd_rw),
      .lcd_data  (lcd_data)
   );

   task automatic test_reset();
      rst = 1'b1;
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({cmd_ready, lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data} !== 13'h0) begin
         miscompares++;
         $display("FAIL reset_pins: got rdy=%b on=%b en=%b rs=%b rw=%b data=%h, want all 0",
                  cmd_ready, lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data);
      end
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ready: got %b want 1", cmd_ready);
      end
      vectors++;
      if (lcd_on !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_lcd_on: got %b want 1", lcd_on);
      end
      vectors++;
      if ({lcd_en, lcd_rs, lcd_rw, lcd_data} !== 11'h0) begin
         miscompares++;
         $display("FAIL idle_pins: got en=%b rs=%b rw=%b data=%h want 0", lcd_en, lcd_rs, lcd_rw, lcd_data);
      end
   endtask

   task automatic wait_ready(input string name, input int bound);
      int n = 0;
      while (cmd_ready !== 1'b1 && n < bound) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s: cmd_ready still %b after %0d cycles", name, cmd_ready, n);
      end
   endtask

   // Called on a negedge with cmd_ready=1; returns on the negedge where cmd_ready
   // is seen high again, with the next upstream request already driven.
   task automatic run_cmd(input string name, input logic rs, input logic [7:0] d, input int exp_busy,
                          input logic nxt_valid, input logic nxt_rs, input logic [7:0] nxt_d);
      int n = 0;
      int en_first = -1;
      int en_last = -1;
      int en_cnt = 0;
      int unstable = 0;
      int rdy_t = -1;
      cmd_valid = 1'b1;
      cmd_rs = rs;
      cmd_data = d;
      @(negedge clk);
      cmd_valid = nxt_valid;
      cmd_rs = nxt_rs;
      cmd_data = nxt_d;
      vectors++;
      if ({cmd_ready, lcd_en, lcd_rs, lcd_data} !== {1'b0, 1'b0, rs, d}) begin
         miscompares++;
         $display("FAIL %s_accept: got rdy=%b en=%b rs=%b data=%h want rdy=0 en=0 rs=%b data=%h",
                  name, cmd_ready, lcd_en, lcd_rs, lcd_data, rs, d);
      end
      while (rdy_t < 0 && n < exp_busy + 10) begin
         @(negedge clk);
         n++;
         if (lcd_en === 1'b1) begin
            if (en_first < 0) en_first = n;
            en_last = n;
            en_cnt++;
         end
         if (lcd_rs !== rs || lcd_data !== d || lcd_rw !== 1'b0) unstable++;
         if (cmd_ready === 1'b1) rdy_t = n;
      end
      vectors++;
      if (en_first !== 2) begin
         miscompares++;
         $display("FAIL %s_en_rise: got cycle %0d want 2", name, en_first);
      end
      vectors++;
      if (en_cnt !== 3 || en_last !== 4) begin
         miscompares++;
         $display("FAIL %s_en_width: got %0d cycles ending %0d want 3 ending 4", name, en_cnt, en_last);
      end
      vectors++;
      if (unstable !== 0) begin
         miscompares++;
         $display("FAIL %s_pins_stable: got %0d unstable cycles want 0", name, unstable);
      end
      vectors++;
      if (rdy_t !== exp_busy) begin
         miscompares++;
         $display("FAIL %s_busy: got %0d want %0d", name, rdy_t, exp_busy);
      end
   endtask

   task automatic test_send_data();
      run_cmd("data41", 1'b1, 8'h41, 12, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_back_to_back();
      run_cmd("clear01", 1'b0, 8'h01, 27, 1'b1, 1'b0, 8'h80);
      run_cmd("ddram80", 1'b0, 8'h80, 12, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_busy_change();
      run_cmd("busy30", 1'b0, 8'h30, 12, 1'b1, 1'b0, 8'hFF);
      run_cmd("heldFF", 1'b0, 8'hFF, 12, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_long_classify();
      run_cmd("home02", 1'b0, 8'h02, 27, 1'b0, 1'b0, 8'h00);
      run_cmd("home03", 1'b0, 8'h03, 27, 1'b0, 1'b0, 8'h00);
      run_cmd("inst00", 1'b0, 8'h00, 12, 1'b0, 1'b0, 8'h00);
      run_cmd("inst04", 1'b0, 8'h04, 12, 1'b0, 1'b0, 8'h00);
      run_cmd("data01", 1'b1, 8'h01, 12, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_reset_mid();
      int n = 0;
      cmd_valid = 1'b1;
      cmd_rs = 1'b1;
      cmd_data = 8'h5A;
      @(negedge clk);
      cmd_valid = 1'b0;
      while (lcd_en !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (lcd_en !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_en_high: got %b want 1", lcd_en);
      end
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if ({lcd_en, lcd_data, cmd_ready, lcd_rs} !== 11'h0) begin
         miscompares++;
         $display("FAIL mid_reset_pins: got en=%b data=%h rdy=%b rs=%b want 0", lcd_en, lcd_data, cmd_ready, lcd_rs);
      end
      rst = 1'b0;
      wait_ready("mid_reset_recover", 300);
      run_cmd("after_rst", 1'b1, 8'h41, 12, 1'b0, 1'b0, 8'h00);
   endtask

`ifdef LCD_INIT_SEQ_EN
   task automatic test_init();
      int exp_rise [6] = '{13, 26, 39, 52, 65, 93};
      logic [7:0] exp_byte [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
      int rise_t [6];
      logic [7:0] rise_b [6];
      logic rise_rs [6];
      int rises = 0;
      int rdy_t = -1;
      logic en_prev = 1'b0;
      rst = 1'b1;
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int n = 1; n <= 140; n++) begin
         @(negedge clk);
         if (lcd_en === 1'b1 && en_prev === 1'b0) begin
            if (rises < 6) begin
               rise_t[rises] = n;
               rise_b[rises] = lcd_data;
               rise_rs[rises] = lcd_rs;
            end
            rises++;
         end
         en_prev = lcd_en;
         if (cmd_ready === 1'b1 && rdy_t < 0) rdy_t = n;
      end
      vectors++;
      if (rises !== 6) begin
         miscompares++;
         $display("FAIL init_pulses: got %0d want 6", rises);
      end
      for (int i = 0; i < 6; i++) begin
         if (i < rises) begin
            vectors++;
            if (rise_t[i] !== exp_rise[i] || rise_b[i] !== exp_byte[i] || rise_rs[i] !== 1'b0) begin
               miscompares++;
               $display("FAIL init_byte%0d: got t=%0d data=%h rs=%b want t=%0d data=%h rs=0",
                        i, rise_t[i], rise_b[i], rise_rs[i], exp_rise[i], exp_byte[i]);
            end
         end
      end
      vectors++;
      if (rdy_t !== 103) begin
         miscompares++;
         $display("FAIL init_ready: got cycle %0d want 103", rdy_t);
      end
   endtask
`endif

   initial begin
`ifdef LCD_INIT_SEQ_EN
      test_init();
      wait_ready("init_done", 300);
`else
      test_reset();
`endif
      test_send_data();
      test_back_to_back();
      test_busy_change();
      test_long_classify();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
